key_debounce_counter: RTL and testbench

Front-end stage for the DE-series push-buttons: synchronizes and debounces the four active-low KEY inputs, produces one-cycle press events, and keeps a 4-bit digit that the buttons step up, step down or clear. Its `digit` output drives the seven-segment decoder directly. Debounced levels and press pulses are also exported for other consumers.

---
 rtl/key_debounce_counter.sv | 102 ++++++++++
 tb/tb_key_debounce_counter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/key_debounce_counter.sv
// Push-button front end: synchronizes and debounces four active-low keys,
// emits one-cycle press events and steps a 4-bit decimal/hex digit.
module key_debounce_counter #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic [3:0] KEY,
    output logic [3:0] digit,
    output logic       hex_mode,
    output logic [3:0] key_level,
    output logic [3:0] press_pulse,
    output logic       changed
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0] level_d_reg;
    logic [3:0] rise;

    logic [3:0] digit_next;
    logic       hex_next;
    logic       changed_next;
    logic [3:0] max_val;
    logic       inc_evt;
    logic       dec_evt;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            logic          sync1_reg;
            logic          sync2_reg;
            logic          level_reg;
            logic [CW-1:0] cnt_reg;

            // Level only flips after the mismatch has survived the full window.
            always_ff @(posedge CLOCK_50 or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= ~KEY[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_MAX) begin
                        cnt_reg   <= '0;
                        level_reg <= sync2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end

            assign key_level[gi] = level_reg;
        end
    endgenerate

    assign rise    = key_level & ~level_d_reg;
    assign max_val = hex_mode ? 4'd15 : 4'd9;
    assign inc_evt = rise[0] & ~rise[1];
    assign dec_evt = rise[1] & ~rise[0];

    // Clear beats toggle beats inc/dec; toggle alone leaving hex resets an
    // out-of-range digit so decimal mode never shows 10..15.
    always_comb begin
        digit_next = digit;
        hex_next   = hex_mode ^ rise[3];
        if (rise[2]) begin
            digit_next = 4'd0;
        end else if (rise[3]) begin
            if (hex_mode && (digit > 4'd9)) begin
                digit_next = 4'd0;
            end
        end else if (inc_evt) begin
            digit_next = (digit == max_val) ? 4'd0 : digit + 4'd1;
        end else if (dec_evt) begin
            digit_next = (digit == 4'd0) ? max_val : digit - 4'd1;
        end
        changed_next = (digit_next != digit) || (hex_next != hex_mode);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            level_d_reg <= 4'd0;
            press_pulse <= 4'd0;
            digit       <= 4'd0;
            hex_mode    <= 1'b0;
            changed     <= 1'b0;
        end else begin
            level_d_reg <= key_level;
            press_pulse <= rise;
            digit       <= digit_next;
            hex_mode    <= hex_next;
            changed     <= changed_next;
        end
    end

endmodule

// File: tb/tb_key_debounce_counter.sv
// Directed bench for key_debounce_counter with a 4-cycle debounce window.
module tb_key_debounce_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] KEY;
    logic [3:0] digit;
    logic       hex_mode;
    logic [3:0] key_level;
    logic [3:0] press_pulse;
    logic       changed;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt [4] = '{0, 0, 0, 0};
    int chg_cnt = 0;
    int snap_p0;
    int snap_chg;

    always #5 clk = ~clk;

    key_debounce_counter #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50   (clk),
        .rst_n      (rst_n),
        .KEY        (KEY),
        .digit      (digit),
        .hex_mode   (hex_mode),
        .key_level  (key_level),
        .press_pulse(press_pulse),
        .changed    (changed)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) pulse_cnt[i] += int'(press_pulse[i]);
            chg_cnt += int'(changed);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Press keys in mask for 10 cycles, check exact latency of level, pulse,
    // digit, mode and changed, then release and let the release settle.
    task automatic press(input string tag, input logic [3:0] mask, input logic [3:0] exp_digit,
                         input logic exp_hex, input logic exp_changed);
        KEY = KEY & ~mask;
        tick(5);
        chk({tag, ":level_before"}, 32'(key_level), 32'h0);
        tick(1);
        chk({tag, ":level"}, 32'(key_level), 32'(mask));
        chk({tag, ":pulse_early"}, 32'(press_pulse), 32'h0);
        tick(1);
        chk({tag, ":pulse"}, 32'(press_pulse), 32'(mask));
        chk({tag, ":digit"}, 32'(digit), 32'(exp_digit));
        chk({tag, ":hex"}, 32'(hex_mode), 32'(exp_hex));
        chk({tag, ":changed"}, 32'(changed), 32'(exp_changed));
        tick(1);
        chk({tag, ":pulse_end"}, 32'(press_pulse), 32'h0);
        chk({tag, ":changed_end"}, 32'(changed), 32'h0);
        tick(2);
        KEY = 4'b1111;
        tick(8);
        chk({tag, ":released"}, 32'(key_level), 32'h0);
        $display("press %s mask=%b digit=%0d hex=%0d", tag, mask, digit, hex_mode);
    endtask

    initial begin
        KEY   = 4'b1111;
        rst_n = 1'b0;
        tick(3);
        chk("reset_outputs", {20'd0, digit, hex_mode, key_level, press_pulse, changed}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            chk("idle_outputs", {20'd0, digit, hex_mode, key_level, press_pulse, changed}, 32'h0);
        end

        // Reset in the middle of a KEY[0] debounce
        snap_p0 = pulse_cnt[0];
        KEY[0] = 1'b0;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_level", 32'(key_level), 32'h0);
        chk("rst_mid_pulse", 32'(press_pulse), 32'h0);
        KEY = 4'b1111;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("rst_mid_no_pulse", 32'(pulse_cnt[0] - snap_p0), 32'h0);
        chk("rst_mid_digit", 32'(digit), 32'h0);

        // Three KEY[0] presses
        snap_chg = chg_cnt;
        snap_p0  = pulse_cnt[0];
        press("inc1", 4'b0001, 4'd1, 1'b0, 1'b1);
        press("inc2", 4'b0001, 4'd2, 1'b0, 1'b1);
        press("inc3", 4'b0001, 4'd3, 1'b0, 1'b1);
        chk("inc_pulses", 32'(pulse_cnt[0] - snap_p0), 32'd3);
        chk("inc_changed", 32'(chg_cnt - snap_chg), 32'd3);

        // Short glitch and bounce are rejected
        snap_p0 = pulse_cnt[0];
        KEY[0] = 1'b0;
        tick(3);
        KEY[0] = 1'b1;
        tick(10);
        chk("glitch_level", 32'(key_level), 32'h0);
        foreach (KEY[i]) begin end
        KEY[0] = 1'b1; tick(1);
        KEY[0] = 1'b0; tick(1);
        KEY[0] = 1'b1; tick(1);
        KEY[0] = 1'b0; tick(2);
        KEY[0] = 1'b1;
        tick(10);
        chk("bounce_no_pulse", 32'(pulse_cnt[0] - snap_p0), 32'h0);
        chk("bounce_digit", 32'(digit), 32'd3);
        $display("glitch/bounce digit=%0d", digit);

        // Decimal wraps, then hex wraps
        press("clear3", 4'b0100, 4'd0, 1'b0, 1'b1);
        press("dec_wrap", 4'b0010, 4'd9, 1'b0, 1'b1);
        press("inc_wrap", 4'b0001, 4'd0, 1'b0, 1'b1);
        press("to_hex", 4'b1000, 4'd0, 1'b1, 1'b1);
        for (int v = 1; v <= 15; v++) press("hex_inc", 4'b0001, 4'(v), 1'b1, 1'b1);
        press("hex_inc_wrap", 4'b0001, 4'd0, 1'b1, 1'b1);

        // Hex decrement wrap down to 12, then leave hex mode
        press("hex_dec_wrap", 4'b0010, 4'd15, 1'b1, 1'b1);
        press("hex_dec14", 4'b0010, 4'd14, 1'b1, 1'b1);
        press("hex_dec13", 4'b0010, 4'd13, 1'b1, 1'b1);
        press("hex_dec12", 4'b0010, 4'd12, 1'b1, 1'b1);
        snap_chg = chg_cnt;
        press("leave_hex", 4'b1000, 4'd0, 1'b0, 1'b1);
        chk("leave_hex_one_changed", 32'(chg_cnt - snap_chg), 32'd1);
        press("clear_at0", 4'b0100, 4'd0, 1'b0, 1'b0);

        // Clear plus toggle together, then back to decimal
        press("clr_tog", 4'b1100, 4'd0, 1'b1, 1'b1);
        press("tog_back", 4'b1000, 4'd0, 1'b0, 1'b1);

        // Simultaneous inc+dec cancels; clear beats increment
        for (int v = 1; v <= 5; v++) press("to5", 4'b0001, 4'(v), 1'b0, 1'b1);
        press("inc_dec", 4'b0011, 4'd5, 1'b0, 1'b0);
        press("clr_inc", 4'b0101, 4'd0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
